// File: rtl/des_pkg.sv
// Shared types and constants for the triple-DES round sequencing logic.
package des_pkg;

    localparam int unsigned DES_ROUNDS  = 16;
    localparam int unsigned TDES_KEYS   = 3;
    localparam int unsigned ROUND_CNT_W = 5;
    localparam int unsigned KEY_CNT_W   = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROUND,
        DONE
    } seq_state_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and programmable wrap value; flag decodes
// the registered count reaching rollover_val.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_next;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else begin
            count_out <= count_next;
        end
    end

    // Clear wins over enable; an enabled count at rollover_val wraps to zero.
    always_comb begin
        count_next = count_out;
        if (clear) begin
            count_next = '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                count_next = '0;
            end else begin
                count_next = count_out + 1'b1;
            end
        end
    end

    assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/des_round_sequencer.sv
// Sequences one multi-pass (EDE/DED) DES block: per pass one load cycle then
// NUM_ROUNDS round cycles, driving the subkey generator's count/direction inputs.
module des_round_sequencer
    import des_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = DES_ROUNDS,
    parameter int unsigned NUM_KEYS   = TDES_KEYS
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       decrypt,
    input  logic       hold,
    output logic       busy,
    output logic       done,
    output logic [4:0] round_count,
    output logic [1:0] key_count,
    output logic       cnt_rollover,
    output logic       key_rollover,
    output logic       reverse,
    output logic       round_en,
    output logic       load_block
);

    localparam logic [ROUND_CNT_W-1:0] LAST_ROUND = ROUND_CNT_W'(NUM_ROUNDS);
    localparam logic [KEY_CNT_W-1:0]   LAST_KEY   = KEY_CNT_W'(NUM_KEYS - 1);

    seq_state_t state, state_next;
    logic       mode_r;
    logic       rnd_clr, rnd_en, key_clr, key_en;
    logic       last_round, last_key;

    flex_counter #(
        .NUM_CNT_BITS (ROUND_CNT_W)
    ) u_round_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (rnd_clr),
        .count_enable  (rnd_en),
        .rollover_val  (LAST_ROUND),
        .count_out     (round_count),
        .rollover_flag (last_round)
    );

    flex_counter #(
        .NUM_CNT_BITS (KEY_CNT_W)
    ) u_key_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (key_clr),
        .count_enable  (key_en),
        .rollover_val  (LAST_KEY),
        .count_out     (key_count),
        .rollover_flag (last_key)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= IDLE;
            mode_r <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                mode_r <= decrypt;
            end
        end
    end

    always_comb begin
        state_next   = state;
        rnd_clr      = 1'b0;
        rnd_en       = 1'b0;
        key_clr      = 1'b0;
        key_en       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        load_block   = 1'b0;
        round_en     = 1'b0;
        cnt_rollover = 1'b0;
        key_rollover = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    rnd_clr    = 1'b1;
                    key_clr    = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy = 1'b1;
                if (!hold) begin
                    load_block = (key_count == '0);
                    rnd_en     = 1'b1;
                    state_next = ROUND;
                end
            end
            ROUND: begin
                busy = 1'b1;
                if (!hold) begin
                    round_en = 1'b1;
                    if (last_round) begin
                        cnt_rollover = 1'b1;
                        if (last_key) begin
                            // Counters are left at their final values after the last pass.
                            key_rollover = 1'b1;
                            state_next   = DONE;
                        end else begin
                            key_en     = 1'b1;
                            rnd_en     = 1'b1;
                            state_next = LOAD;
                        end
                    end else begin
                        rnd_en = 1'b1;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Middle pass runs opposite to the latched mode (EDE vs DED).
    assign reverse = busy & (mode_r ^ (key_count == 2'd1));

endmodule

// File: tb/tb_des_round_sequencer.sv
// Randomized self-checking bench for des_round_sequencer against a
// position-within-operation reference model.
module tb_des_round_sequencer;

    localparam int R     = 16;
    localparam int N     = 3;
    localparam int OPLEN = N * (R + 1);

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic       decrypt;
    logic       hold;
    logic       busy;
    logic       done;
    logic [4:0] round_count;
    logic [1:0] key_count;
    logic       cnt_rollover;
    logic       key_rollover;
    logic       reverse;
    logic       round_en;
    logic       load_block;

    always #5 clk = ~clk;

    des_round_sequencer #(
        .NUM_ROUNDS (R),
        .NUM_KEYS   (N)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .decrypt      (decrypt),
        .hold         (hold),
        .busy         (busy),
        .done         (done),
        .round_count  (round_count),
        .key_count    (key_count),
        .cnt_rollover (cnt_rollover),
        .key_rollover (key_rollover),
        .reverse      (reverse),
        .round_en     (round_en),
        .load_block   (load_block)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: an operation is a position 0..OPLEN-1; pass = pos/(R+1),
    // phase 0 is the load cycle, phases 1..R are rounds.
    bit m_active  = 1'b0;
    bit m_done    = 1'b0;
    int m_pos     = 0;
    bit m_mode    = 1'b0;
    int m_rc_idle = 0;
    int m_kc_idle = 0;
    int cyc       = 0;
    int acc_cyc   = 0;
    int hold_cnt  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs(input bit h);
        int pass, ph;
        int e_rc, e_kc;
        bit e_busy, e_done, e_lb, e_ren, e_cro, e_kro, e_rev;
        e_busy = 0; e_done = 0; e_lb = 0; e_ren = 0; e_cro = 0; e_kro = 0; e_rev = 0;
        e_rc = m_rc_idle;
        e_kc = m_kc_idle;
        if (m_active) begin
            pass   = m_pos / (R + 1);
            ph     = m_pos % (R + 1);
            e_rc   = ph;
            e_kc   = pass;
            e_busy = 1;
            e_lb   = (ph == 0) && (pass == 0) && !h;
            e_ren  = (ph != 0) && !h;
            e_cro  = (ph == R) && !h;
            e_kro  = e_cro && (pass == N - 1);
            e_rev  = m_mode ^ (pass == 1);
        end else if (m_done) begin
            e_done = 1;
            e_rc   = R;
            e_kc   = N - 1;
        end
        check_val("busy",         32'(busy),         32'(e_busy));
        check_val("done",         32'(done),         32'(e_done));
        check_val("round_count",  32'(round_count),  32'(e_rc));
        check_val("key_count",    32'(key_count),    32'(e_kc));
        check_val("load_block",   32'(load_block),   32'(e_lb));
        check_val("round_en",     32'(round_en),     32'(e_ren));
        check_val("cnt_rollover", 32'(cnt_rollover), 32'(e_cro));
        check_val("key_rollover", 32'(key_rollover), 32'(e_kro));
        check_val("reverse",      32'(reverse),      32'(e_rev));
        if (m_done) begin
            check_val("latency", 32'(cyc - acc_cyc), 32'(1 + OPLEN + hold_cnt));
        end
    endtask

    task automatic tick(input logic s, input logic d, input logic h);
        @(negedge clk);
        start   = s;
        decrypt = d;
        hold    = h;
        #1;
        check_outputs(h);
        @(posedge clk);
        if (m_active) begin
            if (h) begin
                hold_cnt++;
            end else if (m_pos == OPLEN - 1) begin
                m_active = 0;
                m_done   = 1;
            end else begin
                m_pos++;
            end
        end else if (m_done) begin
            m_done    = 0;
            m_rc_idle = R;
            m_kc_idle = N - 1;
        end else if (s) begin
            m_active = 1;
            m_pos    = 0;
            m_mode   = d;
            acc_cyc  = cyc;
            hold_cnt = 0;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        n_rst = 1'b0;
        m_active  = 0;
        m_done    = 0;
        m_mode    = 0;
        m_rc_idle = 0;
        m_kc_idle = 0;
        #1;
        check_outputs(hold);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        int stall_left;
        bit h;
        n_rst   = 1'b0;
        start   = 1'b0;
        decrypt = 1'b0;
        hold    = 1'b0;
        #12;
        n_rst = 1'b1;

        // Reset state and idle stability
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);

        // Encrypt run, single start pulse
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 56; i++) tick(1'b0, 1'b0, 1'b0);

        // Decrypt run with decrypt toggled after acceptance
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 56; i++) tick(1'b0, (i >= 10) ? 1'b0 : 1'b1, 1'b0);

        // Stall for 5 cycles at pass 1, round 9
        tick(1'b1, 1'b0, 1'b0);
        stall_left = 5;
        for (int i = 0; i < 64; i++) begin
            h = m_active && (m_pos == (R + 1) + 9) && (stall_left > 0);
            if (h) stall_left--;
            tick(1'b0, 1'b0, h);
        end

        // start held every cycle: no restart until IDLE, then re-accepted
        for (int i = 0; i < 60; i++) tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 50; i++) tick(1'b0, 1'b0, 1'b0);

        // Mid-operation reset at pass 2, round 5, then a full run
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200 && !(m_active && m_pos == 2 * (R + 1) + 5); i++) begin
            tick(1'b0, 1'b0, 1'b0);
        end
        check_val("reached_reset_point", 32'(m_active && m_pos == 2 * (R + 1) + 5), 32'd1);
        do_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 56; i++) tick(1'b0, 1'b0, 1'b0);

        // Randomized start/decrypt/hold
        for (int run = 0; run < 6; run++) begin
            for (int i = 0; i < 80; i++) begin
                tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
